// File: rtl/mfcc_frame_scheduler_if.sv
// mfcc_frame_scheduler_if
//   Bundles the control, handshake and status signals between the MFCC frame
//   scheduler and the rest of the pipeline (window buffer, Hamming, FFT, Mel,
//   DCT stages and the software-visible status).
//   master : the scheduler side (drives starts, strobes and status).
//   slave  : the pipeline/software side (drives enable, clear, frame_avail
//            and the stage done pulses).
interface mfcc_frame_scheduler_if #(
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int OVR_CNT_WIDTH   = 8
);
  logic                       enable_i;
  logic                       clear_i;
  logic                       frame_avail_i;
  logic                       start_move_o;
  logic                       hamming_start_o;
  logic                       hamming_done_i;
  logic                       fft_start_o;
  logic                       fft_done_i;
  logic                       mel_start_o;
  logic                       mel_done_i;
  logic                       dct_start_o;
  logic                       dct_done_i;
  logic                       busy_o;
  logic [2:0]                 stage_o;
  logic                       frame_done_o;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_o;
  logic                       overrun_o;
  logic [OVR_CNT_WIDTH-1:0]   overrun_count_o;
  logic                       timeout_o;
  logic [2:0]                 error_stage_o;

  modport master (
    input  enable_i, clear_i, frame_avail_i,
    input  hamming_done_i, fft_done_i, mel_done_i, dct_done_i,
    output start_move_o, hamming_start_o, fft_start_o, mel_start_o, dct_start_o,
    output busy_o, stage_o, frame_done_o, frame_count_o,
    output overrun_o, overrun_count_o, timeout_o, error_stage_o
  );

  modport slave (
    output enable_i, clear_i, frame_avail_i,
    output hamming_done_i, fft_done_i, mel_done_i, dct_done_i,
    input  start_move_o, hamming_start_o, fft_start_o, mel_start_o, dct_start_o,
    input  busy_o, stage_o, frame_done_o, frame_count_o,
    input  overrun_o, overrun_count_o, timeout_o, error_stage_o
  );
endinterface

// File: rtl/mfcc_frame_scheduler.sv
// mfcc_frame_scheduler
//   Central sequencer of the MFCC frame pipeline. A frame-ready pulse from the
//   window buffer launches a frame; the scheduler then pulses the Hamming, FFT,
//   Mel and DCT start strobes in turn, each after the previous stage's done.
//   The window-advance strobe is issued with the FFT start. A per-stage
//   watchdog drops the sequencer into ERR if a stage hangs; frame overruns are
//   counted. ERR is left only via clear.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mfcc_frame_scheduler_if.master (control inputs, stage handshakes,
//          frame/overrun/timeout status)
module mfcc_frame_scheduler #(
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int OVR_CNT_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int TO_WIDTH        = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  mfcc_frame_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HAM  = 3'd1,
    FFT  = 3'd2,
    MEL  = 3'd3,
    DCT  = 3'd4,
    ERR  = 3'd7
  } state_t;

  state_t                     state_reg, state_next;
  logic [TO_WIDTH-1:0]        watchdog_reg;
  logic                       pending_reg;

  logic                       start_move_reg;
  logic                       hamming_start_reg;
  logic                       fft_start_reg;
  logic                       mel_start_reg;
  logic                       dct_start_reg;
  logic                       frame_done_reg;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_reg;
  logic                       overrun_reg;
  logic [OVR_CNT_WIDTH-1:0]   ovr_count_reg;
  logic                       timeout_reg;
  logic [2:0]                 error_stage_reg;

  logic launch;
  logic stage_done;
  logic wd_expired;
  logic timeout_hit;
  logic overrun_ev;

  // Done of the current stage only; a done coinciding with its own start
  // pulse belongs to a previous use of the stage and is dropped.
  always_comb begin
    stage_done = 1'b0;
    case (state_reg)
      HAM:     stage_done = bus.hamming_done_i & ~hamming_start_reg;
      FFT:     stage_done = bus.fft_done_i     & ~fft_start_reg;
      MEL:     stage_done = bus.mel_done_i     & ~mel_start_reg;
      DCT:     stage_done = bus.dct_done_i     & ~dct_start_reg;
      default: stage_done = 1'b0;
    endcase
  end

  // Watchdog counts 0 in the start cycle, so a stage may stay busy for
  // exactly TIMEOUT_CYCLES cycles before the switch to ERR.
  assign wd_expired = (watchdog_reg == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next  = state_reg;
    launch      = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.enable_i && (pending_reg || bus.frame_avail_i)) begin
          launch     = 1'b1;
          state_next = HAM;
        end
      end
      HAM: begin
        if (stage_done) begin
          state_next = FFT;
        end else if (wd_expired) begin
          state_next  = ERR;
          timeout_hit = 1'b1;
        end
      end
      FFT: begin
        if (stage_done) begin
          state_next = MEL;
        end else if (wd_expired) begin
          state_next  = ERR;
          timeout_hit = 1'b1;
        end
      end
      MEL: begin
        if (stage_done) begin
          state_next = DCT;
        end else if (wd_expired) begin
          state_next  = ERR;
          timeout_hit = 1'b1;
        end
      end
      DCT: begin
        if (stage_done) begin
          state_next = IDLE;
        end else if (wd_expired) begin
          state_next  = ERR;
          timeout_hit = 1'b1;
        end
      end
      ERR: begin
        if (bus.clear_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A second frame arriving while one is already queued is lost.
  assign overrun_ev = bus.frame_avail_i & pending_reg & ~launch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      watchdog_reg <= '0;
      pending_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_next != state_reg) begin
        watchdog_reg <= '0;
      end else if (state_reg inside {HAM, FFT, MEL, DCT}) begin
        watchdog_reg <= watchdog_reg + TO_WIDTH'(1);
      end

      // On a launch the queued frame is consumed; a frame arriving in the
      // same cycle stays queued only if it is not the one being launched.
      if (state_reg == ERR && bus.clear_i) begin
        pending_reg <= 1'b0;
      end else if (launch) begin
        pending_reg <= pending_reg & bus.frame_avail_i;
      end else begin
        pending_reg <= pending_reg | bus.frame_avail_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_move_reg    <= 1'b0;
      hamming_start_reg <= 1'b0;
      fft_start_reg     <= 1'b0;
      mel_start_reg     <= 1'b0;
      dct_start_reg     <= 1'b0;
      frame_done_reg    <= 1'b0;
      frame_count_reg   <= '0;
      overrun_reg       <= 1'b0;
      ovr_count_reg     <= '0;
      timeout_reg       <= 1'b0;
      error_stage_reg   <= 3'd0;
    end else begin
      hamming_start_reg <= launch;
      // Window frame is consumed once Hamming is finished with it.
      start_move_reg    <= (state_reg == HAM) && (state_next == FFT);
      fft_start_reg     <= (state_reg == HAM) && (state_next == FFT);
      mel_start_reg     <= (state_reg == FFT) && (state_next == MEL);
      dct_start_reg     <= (state_reg == MEL) && (state_next == DCT);
      frame_done_reg    <= (state_reg == DCT) && (state_next == IDLE);

      if ((state_reg == DCT) && (state_next == IDLE)) begin
        frame_count_reg <= frame_count_reg + FRAME_CNT_WIDTH'(1);
      end

      if (bus.clear_i) begin
        overrun_reg   <= 1'b0;
        ovr_count_reg <= '0;
      end else if (overrun_ev) begin
        overrun_reg <= 1'b1;
        if (ovr_count_reg != '1) begin
          ovr_count_reg <= ovr_count_reg + OVR_CNT_WIDTH'(1);
        end
      end

      // A fresh timeout must be recorded even if clear arrives with it.
      if (timeout_hit) begin
        timeout_reg     <= 1'b1;
        error_stage_reg <= state_reg;
      end else if (bus.clear_i) begin
        timeout_reg     <= 1'b0;
        error_stage_reg <= 3'd0;
      end
    end
  end

  assign bus.start_move_o    = start_move_reg;
  assign bus.hamming_start_o = hamming_start_reg;
  assign bus.fft_start_o     = fft_start_reg;
  assign bus.mel_start_o     = mel_start_reg;
  assign bus.dct_start_o     = dct_start_reg;
  assign bus.busy_o          = (state_reg != IDLE);
  assign bus.stage_o         = state_reg;
  assign bus.frame_done_o    = frame_done_reg;
  assign bus.frame_count_o   = frame_count_reg;
  assign bus.overrun_o       = overrun_reg;
  assign bus.overrun_count_o = ovr_count_reg;
  assign bus.timeout_o       = timeout_reg;
  assign bus.error_stage_o   = error_stage_reg;

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// tb_mfcc_frame_scheduler
//   Self-checking bench: a table of per-cycle vectors for a full frame plus
//   racing/stray done cases, hand-written sequences for overrun, timeout,
//   disable, reset and wrap, then a randomized run against a reference model.
module tb_mfcc_frame_scheduler;
  localparam int FCW = 2;
  localparam int OCW = 2;
  localparam int TO  = 10;
  localparam int TOW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mfcc_frame_scheduler_if #(.FRAME_CNT_WIDTH(FCW), .OVR_CNT_WIDTH(OCW)) bus ();

  mfcc_frame_scheduler #(
    .FRAME_CNT_WIDTH(FCW),
    .OVR_CNT_WIDTH(OCW),
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH(TOW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // {start_move, hamming, fft, mel, dct, frame_done}
  function automatic logic [5:0] pulses();
    return {bus.start_move_o, bus.hamming_start_o, bus.fft_start_o,
            bus.mel_start_o, bus.dct_start_o, bus.frame_done_o};
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({pulses(), bus.busy_o, bus.stage_o, bus.frame_count_o,
                bus.overrun_o, bus.overrun_count_o, bus.timeout_o, bus.error_stage_o});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus.frame_avail_i  = 1'b0;
    bus.clear_i        = 1'b0;
    bus.hamming_done_i = 1'b0;
    bus.fft_done_i     = 1'b0;
    bus.mel_done_i     = 1'b0;
    bus.dct_done_i     = 1'b0;
  endtask

  task automatic set_done(input int s);
    case (s)
      1: bus.hamming_done_i = 1'b1;
      2: bus.fft_done_i     = 1'b1;
      3: bus.mel_done_i     = 1'b1;
      4: bus.dct_done_i     = 1'b1;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset outputs", all_out(), 0);
    rst = 1'b0;
    bus.enable_i = 1'b1;
  endtask

  // From an IDLE cycle: launch and run until the start cycle of target.
  task automatic go_to_stage(input int target, input int d);
    bus.frame_avail_i = 1'b1;
    step();
    for (int s = 1; s < target; s++) begin
      repeat (d) step();
      set_done(s);
      step();
    end
  endtask

  typedef struct {
    int         cyc;
    logic [4:0] in;      // {frame_avail, ham_done, fft_done, mel_done, dct_done}
    logic [2:0] stage;
    logic [5:0] pls;
  } vec_t;

  vec_t vecs[23];

  // Reference model state
  int m_stage, m_age, m_count, m_oc, m_es;
  bit m_pend, m_entered, m_fd, m_ovr, m_to;

  function automatic logic [5:0] m_pulses();
    bit busy_entry;
    busy_entry = m_entered;
    return {busy_entry && m_stage == 2, busy_entry && m_stage == 1,
            busy_entry && m_stage == 2, busy_entry && m_stage == 3,
            busy_entry && m_stage == 4, m_fd};
  endfunction

  task automatic model_step(input bit a, input bit en, input bit clr, input logic [4:1] d);
    int  ns;
    bit  launch, to_ev, ovr_ev;
    ns     = m_stage;
    to_ev  = 0;
    launch = (m_stage == 0) && en && (m_pend || a);
    m_fd   = 0;
    if (m_stage == 0) begin
      if (launch) ns = 1;
    end else if (m_stage >= 1 && m_stage <= 4) begin
      if (d[m_stage] && !m_entered) begin
        ns = (m_stage == 4) ? 0 : m_stage + 1;
        if (m_stage == 4) begin
          m_fd    = 1;
          m_count = (m_count + 1) % (1 << FCW);
        end
      end else if (m_age == TO) begin
        ns    = 7;
        to_ev = 1;
        m_to  = 1;
        m_es  = m_stage;
      end
    end else if (clr) begin
      ns = 0;
    end
    ovr_ev = a && m_pend && !launch;
    if (m_stage == 7 && clr) m_pend = 0;
    else if (launch)         m_pend = m_pend && a;
    else                     m_pend = m_pend || a;
    if (clr) begin
      m_ovr = 0;
      m_oc  = 0;
      if (!to_ev) begin
        m_to = 0;
        m_es = 0;
      end
    end else if (ovr_ev) begin
      m_ovr = 1;
      if (m_oc < (1 << OCW) - 1) m_oc++;
    end
    m_entered = (ns != m_stage) && ns >= 1 && ns <= 4;
    m_age     = (ns != m_stage) ? 1 : m_age + 1;
    m_stage   = ns;
  endtask

  initial begin
    int cyc;
    bus.enable_i       = 1'b0;
    bus.clear_i        = 1'b0;
    bus.frame_avail_i  = 1'b0;
    bus.hamming_done_i = 1'b0;
    bus.fft_done_i     = 1'b0;
    bus.mel_done_i     = 1'b0;
    bus.dct_done_i     = 1'b0;

    vecs[0]  = '{0,  5'b10000, 3'd0, 6'b000000};
    vecs[1]  = '{1,  5'b00000, 3'd1, 6'b010000};
    vecs[2]  = '{6,  5'b01000, 3'd1, 6'b000000};
    vecs[3]  = '{7,  5'b00000, 3'd2, 6'b101000};
    vecs[4]  = '{12, 5'b00100, 3'd2, 6'b000000};
    vecs[5]  = '{13, 5'b00000, 3'd3, 6'b000100};
    vecs[6]  = '{18, 5'b00010, 3'd3, 6'b000000};
    vecs[7]  = '{19, 5'b00000, 3'd4, 6'b000010};
    vecs[8]  = '{24, 5'b00001, 3'd4, 6'b000000};
    vecs[9]  = '{25, 5'b00000, 3'd0, 6'b000001};
    vecs[10] = '{26, 5'b00000, 3'd0, 6'b000000};
    vecs[11] = '{27, 5'b10000, 3'd0, 6'b000000};
    vecs[12] = '{28, 5'b01010, 3'd1, 6'b010000};  // own-start done + stray mel done
    vecs[13] = '{29, 5'b00000, 3'd1, 6'b000000};
    vecs[14] = '{30, 5'b01000, 3'd1, 6'b000000};
    vecs[15] = '{31, 5'b00100, 3'd2, 6'b101000};
    vecs[16] = '{32, 5'b00000, 3'd2, 6'b000000};
    vecs[17] = '{33, 5'b00100, 3'd2, 6'b000000};
    vecs[18] = '{34, 5'b00010, 3'd3, 6'b000100};
    vecs[19] = '{35, 5'b00010, 3'd3, 6'b000000};
    vecs[20] = '{36, 5'b00001, 3'd4, 6'b000010};
    vecs[21] = '{37, 5'b00001, 3'd4, 6'b000000};
    vecs[22] = '{38, 5'b00000, 3'd0, 6'b000001};

    // ---- table-driven frames ----
    do_reset();
    cyc = 0;
    for (int i = 0; i < 23; i++) begin
      while (cyc < vecs[i].cyc) begin
        step();
        cyc++;
      end
      chk($sformatf("vec%0d stage", i), bus.stage_o, vecs[i].stage);
      chk($sformatf("vec%0d pulses", i), pulses(), vecs[i].pls);
      chk($sformatf("vec%0d busy", i), bus.busy_o, vecs[i].stage != 0);
      {bus.frame_avail_i, bus.hamming_done_i, bus.fft_done_i,
       bus.mel_done_i, bus.dct_done_i} = vecs[i].in;
      step();
      cyc++;
    end
    chk("table frame_count", bus.frame_count_o, 2);

    // ---- overrun and saturation ----
    do_reset();
    go_to_stage(2, 5);
    bus.frame_avail_i = 1'b1;
    step();
    step();
    bus.frame_avail_i = 1'b1;
    step();
    chk("ovr flag", bus.overrun_o, 1);
    chk("ovr count", bus.overrun_count_o, 1);
    step();
    step();
    set_done(2);
    step();
    repeat (5) step();
    set_done(3);
    step();
    repeat (5) step();
    set_done(4);
    step();
    chk("ovr frame_done", bus.frame_done_o, 1);
    chk("ovr frame_count", bus.frame_count_o, 1);
    step();
    chk("ovr relaunch ham_start", bus.hamming_start_o, 1);
    bus.frame_avail_i = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      bus.frame_avail_i = 1'b1;
      step();
    end
    chk("ovr count saturate", bus.overrun_count_o, 3);
    bus.clear_i = 1'b1;
    step();
    chk("clear ovr flag", bus.overrun_o, 0);
    chk("clear ovr count", bus.overrun_count_o, 0);
    chk("clear keeps stage", bus.stage_o, 1);

    // ---- timeout ----
    do_reset();
    go_to_stage(2, 2);
    chk("to fft_start", bus.fft_start_o, 1);
    repeat (9) step();
    chk("to stage before", bus.stage_o, 2);
    step();
    chk("to stage err", bus.stage_o, 7);
    chk("to flag", bus.timeout_o, 1);
    chk("to error_stage", bus.error_stage_o, 2);
    for (int k = 0; k < 4; k++) begin
      chk("err no starts", pulses(), 0);
      chk("err busy", bus.busy_o, 1);
      bus.frame_avail_i = 1'b1;
      for (int s = 1; s <= 4; s++) set_done(s);
      step();
    end
    chk("err stays", bus.stage_o, 7);
    chk("err overrun", bus.overrun_o, 1);
    bus.clear_i = 1'b1;
    step();
    chk("clear stage", bus.stage_o, 0);
    chk("clear timeout", bus.timeout_o, 0);
    chk("clear error_stage", bus.error_stage_o, 0);
    chk("clear overrun", bus.overrun_o, 0);
    step();
    chk("clear pending dropped", bus.stage_o, 0);

    // ---- done racing the timeout ----
    do_reset();
    go_to_stage(2, 2);
    repeat (9) step();
    set_done(2);
    step();
    chk("race stage", bus.stage_o, 3);
    chk("race mel_start", bus.mel_start_o, 1);
    chk("race timeout", bus.timeout_o, 0);

    // ---- enable dropped mid-frame ----
    do_reset();
    go_to_stage(3, 2);
    bus.enable_i      = 1'b0;
    bus.frame_avail_i = 1'b1;
    step();
    step();
    set_done(3);
    step();
    step();
    step();
    set_done(4);
    step();
    chk("dis frame_done", bus.frame_done_o, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dis idle", bus.stage_o, 0);
      chk("dis no ham_start", bus.hamming_start_o, 0);
    end
    bus.enable_i = 1'b1;
    step();
    chk("dis relaunch", bus.hamming_start_o, 1);

    // ---- reset during DCT ----
    do_reset();
    go_to_stage(4, 2);
    chk("rst dct_start", bus.dct_start_o, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst async outputs", all_out(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_done(4);
    step();
    chk("rst late done stage", bus.stage_o, 0);
    chk("rst late done frame_done", bus.frame_done_o, 0);
    chk("rst late done count", bus.frame_count_o, 0);

    // ---- frame counter wrap ----
    do_reset();
    for (int f = 0; f < 5; f++) go_to_stage(5, 2);
    chk("wrap frame_count", bus.frame_count_o, 1);

    // ---- randomized run against the model ----
    do_reset();
    m_stage = 0; m_age = 0; m_count = 0; m_oc = 0; m_es = 0;
    m_pend = 0; m_entered = 0; m_fd = 0; m_ovr = 0; m_to = 0;
    for (int n = 0; n < 3000; n++) begin
      bit a, en, clr;
      logic [4:1] d;
      chk($sformatf("rand%0d stage", n), bus.stage_o, m_stage);
      chk($sformatf("rand%0d pulses", n), pulses(), m_pulses());
      chk($sformatf("rand%0d frame_count", n), bus.frame_count_o, m_count);
      chk($sformatf("rand%0d overrun", n), {bus.overrun_o, bus.overrun_count_o}, {m_ovr, 2'(m_oc)});
      chk($sformatf("rand%0d timeout", n), {bus.timeout_o, bus.error_stage_o}, {m_to, 3'(m_es)});
      a   = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 63) == 0);
      for (int s = 1; s <= 4; s++) d[s] = ($urandom_range(0, 3) == 0);
      bus.enable_i       = en;
      bus.frame_avail_i  = a;
      bus.clear_i        = clr;
      bus.hamming_done_i = d[1];
      bus.fft_done_i     = d[2];
      bus.mel_done_i     = d[3];
      bus.dct_done_i     = d[4];
      model_step(a, en, clr, d);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
